line_buffer_ring: RTL and testbench

Parametrised successor to the single ping-pong line RAM inside the Maria video block. It holds up to `NUM_BUFS` scanline buffers in a ring. DMA writes pixel bytes into the current write buffer while video playback reads the previously completed buffer through a registered palette lookup. It adds three behaviours the original lacks: configurable depth, configurable pixel and palette widths, and a deferred-swap handshake.

---
 rtl/line_buffer_pkg.sv | 41 ++++
 rtl/line_buffer_unpack.sv | 58 +++++
 rtl/line_buffer_ring.sv | 267 ++++++++++++++++++++++++++
 tb/tb_line_buffer_ring.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_pkg.sv
// Shared types and helpers for the scanline ring buffer.
//
// Contents:
//   DEF_IDX_W / DEF_PAL_W : default pixel-index and palette-select widths
//   BLACK                 : colour driven in the border when black is selected
//   pix_entry_t           : one stored pixel, {pal, idx}, at the default widths
//   swap_state_t          : states of the deferred line-swap handshake
//   color_index()         : maps {pal, idx} to a colour-map entry number
package line_buffer_pkg;

    localparam int DEF_IDX_W = 2;
    localparam int DEF_PAL_W = 3;

    localparam logic [7:0] BLACK = 8'h00;

    typedef struct packed {
        logic [DEF_PAL_W-1:0] pal;
        logic [DEF_IDX_W-1:0] idx;
    } pix_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ADVANCE = 2'd2
    } swap_state_t;

    // Entry 0 is the background. Each palette owns (2**idx_w - 1) entries
    // for indices 1..max, so entry = 1 + pal*(2**idx_w-1) + (idx-1); the
    // +1 and -1 cancel.
    function automatic int unsigned color_index(input int unsigned pal,
                                                input int unsigned idx,
                                                input int unsigned idx_w);
        int unsigned per_pal;
        per_pal = (32'd1 << idx_w) - 32'd1;
        if (idx == 32'd0) begin
            return 32'd0;
        end
        return pal * per_pal + idx;
    endfunction

endpackage

// File: rtl/line_buffer_unpack.sv
// Byte-to-pixel serializer for the line buffer write path.
//
// A byte accepted on pix_valid & pix_ready is shifted out MSB-first as
// PPB = 8/IDX_W pixel indices, one per cycle, starting the cycle after
// acceptance. A new byte may be accepted while the last pixel of the
// previous one is being emitted, giving one byte every PPB cycles.
//
// Ports:
//   sysclk, reset : clock, synchronous active-high reset
//   pix_in        : pixel byte, leftmost pixel in the MSBs
//   pix_valid     : byte offered
//   hold          : blocks acceptance (a line swap is in progress)
//   pix_ready     : byte can be accepted this cycle
//   accept        : byte taken this cycle (pix_valid & pix_ready)
//   out_valid     : out_idx carries a pixel this cycle
//   out_idx       : current pixel index
//   out_last      : current pixel is the last of its byte
module line_buffer_unpack #(
    parameter int IDX_W = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic [7:0]       pix_in,
    input  logic             pix_valid,
    input  logic             hold,
    output logic             pix_ready,
    output logic             accept,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    localparam int PPB   = 8 / IDX_W;
    localparam int CNT_W = $clog2(PPB + 1);

    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] cnt_reg;   // pixels still to emit, including the current one

    assign out_valid = (cnt_reg != '0);
    assign out_last  = (cnt_reg == CNT_W'(1));
    assign out_idx   = shift_reg[7 -: IDX_W];
    assign pix_ready = !hold && (cnt_reg <= CNT_W'(1));
    assign accept    = pix_valid && pix_ready;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (accept) begin
            shift_reg <= pix_in;
            cnt_reg   <= CNT_W'(PPB);
        end else if (out_valid) begin
            shift_reg <= shift_reg << IDX_W;
            cnt_reg   <= cnt_reg - 1'b1;
        end
    end

endmodule

// File: rtl/line_buffer_ring.sv
// Ring of NUM_BUFS scanline buffers with a palette-lookup playback port.
//
// DMA pixel bytes are serialized into the write buffer wb; playback reads
// the previously completed buffer rb = wb-1 (mod NUM_BUFS). An end-of-line
// swap_req advances the ring, waiting for the serializer to drain first.
//
// Ports:
//   sysclk, reset          : clock, synchronous active-high reset
//   wr_addr, wr_addr_load  : start column for the next accepted byte
//   pal_in, pal_load       : palette tag for the next accepted byte
//   kangaroo               : 0 = index 0 not written (transparent)
//   pix_in, pix_valid,
//   pix_ready              : pixel byte handshake
//   swap_req, swap_ack     : end-of-line request / one-cycle advance pulse
//   rd_en, rd_col          : playback strobe and column
//   color_map              : NCOL packed 8-bit entries, entry 0 = background
//   border_black           : black rather than background outside the line
//   color_kill             : clears the chroma nibble uv_out[7:4]
//   uv_out                 : registered colour, valid 1 cycle after rd_en
//
// Build option LINE_BUFFER_CLEAR_ON_READ_EN: when defined, every in-range
// playback read writes {0,0} back to that entry on the following cycle, so
// a buffer comes round to the producer already transparent.
module line_buffer_ring
    import line_buffer_pkg::*;
#(
    parameter  int COLS     = 160,
    parameter  int IDX_W    = DEF_IDX_W,
    parameter  int PAL_W    = DEF_PAL_W,
    parameter  int NUM_BUFS = 2,
    localparam int CW       = $clog2(COLS),
    localparam int NCOL     = 1 + (2**PAL_W) * (2**IDX_W - 1)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [CW-1:0]     wr_addr,
    input  logic              wr_addr_load,
    input  logic [PAL_W-1:0]  pal_in,
    input  logic              pal_load,
    input  logic              kangaroo,
    input  logic [7:0]        pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic              rd_en,
    input  logic [9:0]        rd_col,
    input  logic [NCOL*8-1:0] color_map,
    input  logic              border_black,
    input  logic              color_kill,
    output logic [7:0]        uv_out
);

    localparam int ENT_W = PAL_W + IDX_W;
    localparam int DEPTH = NUM_BUFS * COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(NUM_BUFS);
    localparam int CIW   = $clog2(NCOL);

    // ---------------------------------------------------------------
    // Serializer
    // ---------------------------------------------------------------
    logic             hold;
    logic             accept;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    line_buffer_unpack #(
        .IDX_W (IDX_W)
    ) u_unpack (
        .sysclk    (sysclk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .hold      (hold),
        .pix_ready (pix_ready),
        .accept    (accept),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // ---------------------------------------------------------------
    // Swap FSM
    // ---------------------------------------------------------------
    swap_state_t state_reg, state_next;
    logic        ser_idle;

    // A byte taken this cycle still has all its pixels to write, so it
    // counts as busy.
    assign ser_idle = !out_valid && !accept;
    assign hold     = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        swap_ack   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (swap_req) begin
                    state_next = ser_idle ? ADVANCE : PENDING;
                end
            end
            PENDING: begin
                // Leave once the final pixel is being written this cycle.
                if (!out_valid || out_last) begin
                    state_next = ADVANCE;
                end
            end
            ADVANCE: begin
                swap_ack   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Write-side control: pointers, column and palette staging
    // ---------------------------------------------------------------
    logic [BW-1:0]    wb_reg;
    logic [BW-1:0]    rb;
    logic [CW-1:0]    wcol_reg;
    logic [CW-1:0]    col_inc;
    logic [CW-1:0]    col_stage_reg;
    logic             col_pending_reg;
    logic [PAL_W-1:0] pal_reg;
    logic [PAL_W-1:0] pal_stage_reg;
    logic [7:0]       uv_next;
    logic [7:0]       uv_out_reg;

    assign rb      = (wb_reg == '0) ? BW'(NUM_BUFS - 1) : wb_reg - 1'b1;
    assign col_inc = (wcol_reg == CW'(COLS - 1)) ? '0 : wcol_reg + 1'b1;
    assign uv_out  = uv_out_reg;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg       <= IDLE;
            wb_reg          <= BW'(1);
            wcol_reg        <= '0;
            col_stage_reg   <= '0;
            col_pending_reg <= 1'b0;
            pal_reg         <= '0;
            pal_stage_reg   <= '0;
            uv_out_reg      <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == ADVANCE) begin
                wb_reg <= (wb_reg == BW'(NUM_BUFS - 1)) ? '0 : wb_reg + 1'b1;
            end

            // Loads are staged so a byte already in flight keeps the
            // column/palette it started with.
            if (pal_load) begin
                pal_stage_reg <= pal_in;
            end
            if (wr_addr_load) begin
                col_stage_reg   <= wr_addr;
                col_pending_reg <= 1'b1;
            end

            if (accept) begin
                pal_reg         <= pal_load ? pal_in : pal_stage_reg;
                col_pending_reg <= 1'b0;
                if (wr_addr_load) begin
                    wcol_reg <= wr_addr;
                end else if (col_pending_reg) begin
                    wcol_reg <= col_stage_reg;
                end else if (out_valid) begin
                    wcol_reg <= col_inc;
                end
            end else if (out_valid) begin
                wcol_reg <= col_inc;
            end

            if (rd_en) begin
                uv_out_reg <= uv_next;
            end
        end
    end

    // ---------------------------------------------------------------
    // Ring storage. Playback must produce a colour one cycle after
    // rd_en, so the read is combinational and the lookup result is what
    // gets registered.
    // ---------------------------------------------------------------
    logic [ENT_W-1:0] ram [DEPTH];
    logic [AW-1:0]    wr_ram_addr;
    logic             pix_we;
    logic             rd_in_range;
    logic [CW-1:0]    rd_col_sel;
    logic [AW-1:0]    rd_ram_addr;
    logic [ENT_W-1:0] rd_entry;
    logic [PAL_W-1:0] rd_pal;
    logic [IDX_W-1:0] rd_idx;

    assign wr_ram_addr = AW'(int'(wb_reg) * COLS + int'(wcol_reg));
    assign pix_we      = out_valid && !reset && (kangaroo || (out_idx != '0));

    assign rd_in_range = (int'(rd_col) < COLS);
    assign rd_col_sel  = rd_in_range ? rd_col[CW-1:0] : '0;
    assign rd_ram_addr = AW'(int'(rb) * COLS + int'(rd_col_sel));
    assign rd_entry    = ram[rd_ram_addr];
    assign rd_pal      = rd_entry[ENT_W-1:IDX_W];
    assign rd_idx      = rd_entry[IDX_W-1:0];

`ifdef LINE_BUFFER_CLEAR_ON_READ_EN
    // The full address is captured so a swap between the read and the
    // clear cannot redirect the clear into another buffer.
    logic          clr_valid_reg;
    logic [AW-1:0] clr_addr_reg;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            clr_valid_reg <= 1'b0;
            clr_addr_reg  <= '0;
        end else begin
            clr_valid_reg <= rd_en && rd_in_range;
            clr_addr_reg  <= rd_ram_addr;
        end
    end

    // With two buffers a swap right after a read can make the cleared
    // entry part of the new write buffer; the pixel write is ordered last
    // so fresh data wins.
    always_ff @(posedge sysclk) begin
        if (clr_valid_reg) begin
            ram[clr_addr_reg] <= '0;
        end
        if (pix_we) begin
            ram[wr_ram_addr] <= {pal_reg, out_idx};
        end
    end
`else
    always_ff @(posedge sysclk) begin
        if (pix_we) begin
            ram[wr_ram_addr] <= {pal_reg, out_idx};
        end
    end
`endif

    // ---------------------------------------------------------------
    // Palette lookup
    // ---------------------------------------------------------------
    logic [7:0]     cmap [NCOL];
    logic [CIW-1:0] ci;

    for (genvar gi = 0; gi < NCOL; gi++) begin : g_cmap
        assign cmap[gi] = color_map[gi*8 +: 8];
    end

    assign ci = CIW'(color_index(32'(rd_pal), 32'(rd_idx), IDX_W));

    always_comb begin
        uv_next = cmap[0];
        if (!rd_in_range) begin
            uv_next = border_black ? BLACK : cmap[0];
        end else if (rd_idx != '0) begin
            uv_next = cmap[ci];
        end
        if (color_kill) begin
            uv_next[7:4] = 4'h0;
        end
    end

endmodule

// File: tb/tb_line_buffer_ring.sv
// Self-checking bench for line_buffer_ring (three-deep ring, default widths).
// A line-level model holds what every buffer column should contain and
// which buffer is being written; playback results are predicted from it.
module tb_line_buffer_ring;
    import line_buffer_pkg::*;

    localparam int COLS = 160;
    localparam int NB   = 3;
    localparam int NCOL = 25;
    localparam int PPB  = 4;

    logic              sysclk = 1'b0;
    logic              reset;
    logic [7:0]        wr_addr;
    logic              wr_addr_load;
    logic [2:0]        pal_in;
    logic              pal_load;
    logic              kangaroo;
    logic [7:0]        pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic              swap_req;
    logic              swap_ack;
    logic              rd_en;
    logic [9:0]        rd_col;
    logic [NCOL*8-1:0] color_map;
    logic              border_black;
    logic              color_kill;
    logic [7:0]        uv_out;

    logic [7:0] cmap_tb [NCOL];
    for (genvar gi = 0; gi < NCOL; gi++) begin : g_cmap
        assign color_map[gi*8 +: 8] = cmap_tb[gi];
    end

    line_buffer_ring #(
        .COLS     (COLS),
        .IDX_W    (2),
        .PAL_W    (3),
        .NUM_BUFS (NB)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .wr_addr      (wr_addr),
        .wr_addr_load (wr_addr_load),
        .pal_in       (pal_in),
        .pal_load     (pal_load),
        .kangaroo     (kangaroo),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .rd_en        (rd_en),
        .rd_col       (rd_col),
        .color_map    (color_map),
        .border_black (border_black),
        .color_kill   (color_kill),
        .uv_out       (uv_out)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Reference model
    pix_entry_t model_mem   [NB][COLS];
    bit         model_known [NB][COLS];
    int         m_wb, m_col, m_pal;
    int         last_acc_cyc;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic int model_rb();
        return (m_wb + NB - 1) % NB;
    endfunction

    function automatic logic [7:0] exp_color(input int col, input int rbuf);
        logic [7:0] c;
        if (col >= COLS) c = border_black ? 8'h00 : cmap_tb[0];
        else if (model_mem[rbuf][col].idx == 2'd0) c = cmap_tb[0];
        else c = cmap_tb[int'(model_mem[rbuf][col].pal) * 3 + int'(model_mem[rbuf][col].idx)];
        if (color_kill) c = c & 8'h0F;
        return c;
    endfunction

    task automatic load_pal(input int p);
        pal_in = 3'(p); pal_load = 1'b1;
        tick();
        pal_load = 1'b0;
        m_pal = p;
    endtask

    task automatic load_addr(input int a);
        wr_addr = 8'(a); wr_addr_load = 1'b1;
        tick();
        wr_addr_load = 1'b0;
        m_col = a;
    endtask

    // Offers a byte, waits (bounded) for ready, returns in the cycle after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        pix_in = b; pix_valid = 1'b1;
        while (!pix_ready && n < 40) begin
            tick();
            n++;
        end
        check_val("accept_wait", {31'd0, pix_ready}, 32'd1);
        last_acc_cyc = cyc;
        tick();
        pix_valid = 1'b0;
        for (int k = 0; k < PPB; k++) begin
            int idx;
            idx = int'((b >> (6 - 2 * k)) & 8'h03);
            if (kangaroo || idx != 0) begin
                model_mem[m_wb][m_col].pal   = 3'(m_pal);
                model_mem[m_wb][m_col].idx   = 2'(idx);
                model_known[m_wb][m_col]     = 1'b1;
            end
            m_col = (m_col + 1) % COLS;
        end
    endtask

    task automatic drain();
        repeat (PPB + 2) tick();
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check_val("swap_ack_idle", {31'd0, swap_ack}, 32'd1);
        tick();
        check_val("swap_ack_pulse", {31'd0, swap_ack}, 32'd0);
        m_wb = (m_wb + 1) % NB;
    endtask

    task automatic read_check(input int col);
        logic [7:0] e;
        int rbuf;
        bit known;
        rbuf  = model_rb();
        known = (col >= COLS) || model_known[rbuf][col];
        e     = exp_color(col, rbuf);
        rd_col = 10'(col); rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (known) check_val($sformatf("rd_b%0d_c%0d", rbuf, col), {24'd0, uv_out}, {24'd0, e});
`ifdef LINE_BUFFER_CLEAR_ON_READ_EN
        if (col < COLS) begin
            model_mem[rbuf][col] = '0;
            model_known[rbuf][col] = 1'b1;
        end
`endif
    endtask

    initial begin
        int plan_idx [4];
        int lat;
        int first_acc;
        logic [7:0] prev;

        reset = 1'b1; wr_addr = '0; wr_addr_load = 1'b0; pal_in = '0; pal_load = 1'b0;
        kangaroo = 1'b1; pix_in = '0; pix_valid = 1'b0; swap_req = 1'b0;
        rd_en = 1'b0; rd_col = '0; border_black = 1'b0; color_kill = 1'b0;
        for (int i = 0; i < NCOL; i++) cmap_tb[i] = 8'($urandom);
        cmap_tb[0] = 8'h3A;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < COLS; c++) begin
                model_known[b][c] = 1'b0;
                model_mem[b][c]   = '0;
            end
        m_wb = 1; m_col = 0; m_pal = 0;

        tick(); tick();
        reset = 1'b0;
        check_val("rst_pix_ready", {31'd0, pix_ready}, 32'd1);
        check_val("rst_swap_ack", {31'd0, swap_ack}, 32'd0);
        check_val("rst_uv_out", {24'd0, uv_out}, 32'd0);

        // Reset in the middle of a byte: remaining pixels dropped, back to idle.
        send_byte(8'hFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < PPB; c++) model_known[1][c] = 1'b0;
        m_wb = 1; m_col = 0; m_pal = 0;
        check_val("midrst_pix_ready", {31'd0, pix_ready}, 32'd1);
        check_val("midrst_swap_ack", {31'd0, swap_ack}, 32'd0);

        // Basic write scenario
        kangaroo = 1'b1;
        load_addr(10); load_pal(5);
        send_byte(8'b11_10_01_00);
        drain();
        do_swap();
        plan_idx = '{18, 17, 16, 0};
        for (int i = 0; i < 4; i++) begin
            read_check(10 + i);
            check_val($sformatf("plan_wr_c%0d", 10 + i), {24'd0, uv_out}, {24'd0, cmap_tb[plan_idx[i]]});
        end

        // Transparency
        load_addr(20); load_pal(1);
        send_byte(8'b10_00_00_00);
        drain();
        kangaroo = 1'b0;
        load_addr(20);
        send_byte(8'h00);
        drain();
        do_swap();
        read_check(20);
        check_val("plan_transp", {24'd0, uv_out}, {24'd0, cmap_tb[5]});
        kangaroo = 1'b1;

        // Column wrap
        load_addr(158); load_pal(0);
        send_byte(8'b01_01_01_01);
        drain();
        do_swap();
        for (int i = 0; i < 4; i++) begin
            read_check((158 + i) % COLS);
            check_val($sformatf("plan_wrap_c%0d", (158 + i) % COLS), {24'd0, uv_out}, {24'd0, cmap_tb[1]});
        end

        // Back-to-back bytes with loads staged mid-byte
        load_addr(80); load_pal(2);
        send_byte(8'hB4);
        first_acc = last_acc_cyc;
        load_pal(6);
        load_addr(100);
        send_byte(8'h6C);
        check_val("b2b_gap", 32'(last_acc_cyc - first_acc), 32'd4);
        drain();
        do_swap();
        for (int i = 0; i < 4; i++) read_check(80 + i);
        for (int i = 0; i < 4; i++) read_check(100 + i);

        // Deferred swap
        load_addr(40); load_pal(2);
        send_byte(8'hE4);
        check_val("ready_drop", {31'd0, pix_ready}, 32'd0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        lat = 1;
        while (!swap_ack && lat < 20) begin
            check_val($sformatf("ready_pending_%0d", lat), {31'd0, pix_ready}, 32'd0);
            tick();
            lat++;
        end
        check_val("ready_at_ack", {31'd0, pix_ready}, 32'd0);
        check_val("deferred_latency", 32'(lat), 32'd4);
        tick();
        m_wb = (m_wb + 1) % NB;
        for (int i = 0; i < 4; i++) read_check(40 + i);

        // Border and colour kill
        border_black = 1'b1;
        read_check(170);
        check_val("plan_border_black", {24'd0, uv_out}, 32'h00);
        border_black = 1'b0; color_kill = 1'b1;
        read_check(170);
        check_val("plan_border_kill", {24'd0, uv_out}, 32'h0A);
        color_kill = 1'b0;

        // Ring depth: read after one swap, then again three swaps later
        load_addr(60); load_pal(3);
        send_byte(8'hFF);
        drain();
        do_swap();
        for (int i = 0; i < 4; i++) read_check(60 + i);
        do_swap(); do_swap(); do_swap();
        for (int i = 0; i < 4; i++) read_check(60 + i);

        // Randomized lines
        for (int line = 0; line < 30; line++) begin
            int addr, nbytes;
            kangaroo = 1'($urandom);
            addr     = $urandom_range(0, COLS - 1);
            nbytes   = $urandom_range(1, 8);
            load_addr(addr);
            load_pal($urandom_range(0, 7));
            for (int b = 0; b < nbytes; b++) send_byte(8'($urandom));
            drain();
            do_swap();
            for (int r = 0; r < 8; r++) begin
                color_kill   = 1'($urandom);
                border_black = 1'($urandom);
                read_check((addr + $urandom_range(0, 4 * nbytes - 1)) % COLS);
            end
            read_check($urandom_range(0, 199));
            prev   = uv_out;
            rd_col = 10'($urandom_range(0, 199));
            rd_en  = 1'b0;
            tick();
            check_val($sformatf("hold_l%0d", line), {24'd0, uv_out}, {24'd0, prev});
            color_kill = 1'b0; border_black = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
